// File: rtl/soc_dmem_arbiter_pkg.sv
// Shared FSM encoding and width helpers for the data-RAM arbiter.
package soc_dmem_arbiter_pkg;
  localparam int XLEN_32b = 1;
  localparam int XLEN_64b = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RMW_MERGE,
    ST_DMA_RD
  } state_t;

  function automatic int dw_of(input int xlen);
    return 1 << (xlen + 4);
  endfunction

  function automatic int offw_of(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/soc_dmem_lane_merge.sv
// Splices a byte or aligned half into an old RAM word for read-modify-write stores.
module soc_dmem_lane_merge
  import soc_dmem_arbiter_pkg::*;
#(
  parameter int  DW   = 64,
  localparam int NB   = DW / 8,
  localparam int OFFW = offw_of(DW)
) (
  input  logic [DW-1:0]   i_old,
  input  logic [15:0]     i_new,
  input  logic [OFFW-1:0] i_off,
  input  logic            i_byte,
  output logic [DW-1:0]   o_merged
);
  always_comb begin
    o_merged = i_old;
    for (int l = 0; l < NB; l++) begin
      if (l == int'(i_off))
        o_merged[l*8 +: 8] = i_new[7:0];
      else if (!i_byte && l == int'(i_off) + 1)
        o_merged[l*8 +: 8] = i_new[15:8];
    end
  end
endmodule

// File: rtl/soc_dmem_arbiter.sv
// Shares the single data-RAM port between the core M-stage and a DMA port,
// running byte/half stores as read-modify-write and stalling the core meanwhile.
// state        | meaning
// ST_IDLE      | arbitrate, issue single-cycle access or first half of a 2-cycle one
// ST_RD_WAIT   | core load data returning from RAM
// ST_RMW_MERGE | old word returning, merged word written back
// ST_DMA_RD    | DMA read data returning from RAM
module soc_dmem_arbiter
  import soc_dmem_arbiter_pkg::*;
#(
  parameter int  XLEN       = XLEN_64b,
  parameter int  RAM_AW     = 10,
  parameter int  STARVE_MAX = 4,
  localparam int DW         = dw_of(XLEN),
  localparam int OFFW       = offw_of(DW),
  localparam int CW         = $clog2(STARVE_MAX + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_core_ram_en,
  input  logic              i_core_sw,
  input  logic              i_core_sbyte,
  input  logic              i_core_shalf,
  input  logic [DW-1:0]     i_core_addr,
  input  logic [DW-1:0]     i_core_wdata,
  output logic [DW-1:0]     o_core_rdata,
  output logic              o_core_rvalid,
  output logic              o_stall,
  output logic              o_misalign,
  input  logic              i_dma_valid,
  input  logic              i_dma_we,
  input  logic [RAM_AW-1:0] i_dma_waddr,
  input  logic [DW-1:0]     i_dma_wdata,
  output logic              o_dma_ready,
  output logic [DW-1:0]     o_dma_rdata,
  output logic              o_dma_rvalid,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [DW-1:0]     o_ram_wdata,
  input  logic [DW-1:0]     i_ram_rdata
);
  state_t            r_state;
  logic [CW-1:0]     r_starve;
  logic [RAM_AW-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [OFFW-1:0]   r_off;
  logic              r_sbyte;

  logic              w_dma_win;
  logic              w_core_go;
  logic              w_sub;
  logic              w_misal;
  logic [OFFW-1:0]   w_off;
  logic [RAM_AW-1:0] w_core_waddr;
  logic [DW-1:0]     w_merged;
  logic              w_unused_addr;

  assign w_off         = i_core_addr[OFFW-1:0];
  assign w_core_waddr  = i_core_addr[OFFW +: RAM_AW];
  assign w_unused_addr = ^i_core_addr[DW-1:OFFW+RAM_AW];
  assign w_dma_win     = i_dma_valid && (!i_core_ram_en || r_starve == CW'(STARVE_MAX));
  assign w_core_go     = i_core_ram_en && !w_dma_win;
  assign w_sub         = i_core_sw && (i_core_sbyte || i_core_shalf);
  assign w_misal       = i_core_sw && !i_core_sbyte && i_core_shalf && w_off[0];

  soc_dmem_lane_merge #(.DW(DW)) u_merge (
    .i_old    (i_ram_rdata),
    .i_new    (r_wdata),
    .i_off    (r_off),
    .i_byte   (r_sbyte),
    .o_merged (w_merged)
  );

  // Outputs are forced low while reset is asserted so an aborted RMW never writes.
  always_comb begin
    o_ram_en      = 1'b0;
    o_ram_we      = 1'b0;
    o_ram_addr    = '0;
    o_ram_wdata   = '0;
    o_stall       = 1'b0;
    o_misalign    = 1'b0;
    o_core_rvalid = 1'b0;
    o_core_rdata  = '0;
    o_dma_ready   = 1'b0;
    o_dma_rvalid  = 1'b0;
    o_dma_rdata   = '0;
    if (!i_rst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_dma_win) begin
            o_dma_ready = 1'b1;
            o_ram_en    = 1'b1;
            o_ram_we    = i_dma_we;
            o_ram_addr  = i_dma_waddr;
            o_ram_wdata = i_dma_wdata;
            o_stall     = i_core_ram_en;
          end else if (w_core_go) begin
            if (w_misal) begin
              o_misalign = 1'b1;
            end else begin
              o_ram_en   = 1'b1;
              o_ram_addr = w_core_waddr;
              if (i_core_sw && !w_sub) begin
                o_ram_we    = 1'b1;
                o_ram_wdata = i_core_wdata;
              end else begin
                o_stall = 1'b1;
              end
            end
          end
        end
        ST_RD_WAIT: begin
          o_core_rvalid = 1'b1;
          o_core_rdata  = i_ram_rdata;
        end
        ST_RMW_MERGE: begin
          o_ram_en    = 1'b1;
          o_ram_we    = 1'b1;
          o_ram_addr  = r_addr;
          o_ram_wdata = w_merged;
        end
        ST_DMA_RD: begin
          o_dma_rvalid = 1'b1;
          o_dma_rdata  = i_ram_rdata;
          o_stall      = i_core_ram_en;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_starve <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_off    <= '0;
      r_sbyte  <= 1'b0;
    end else begin
      if (!i_dma_valid || (r_state == ST_IDLE && w_dma_win))
        r_starve <= '0;
      else if (r_state == ST_IDLE && w_core_go)
        r_starve <= r_starve + CW'(1);

      case (r_state)
        ST_IDLE: begin
          if (w_dma_win) begin
            if (!i_dma_we) r_state <= ST_DMA_RD;
          end else if (w_core_go) begin
            if (!i_core_sw) begin
              r_state <= ST_RD_WAIT;
            end else if (w_sub && !w_misal) begin
              r_state <= ST_RMW_MERGE;
              r_addr  <= w_core_waddr;
              r_wdata <= i_core_wdata[15:0];
              r_off   <= w_off;
              r_sbyte <= i_core_sbyte;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soc_dmem_arbiter.sv
// Self-checking bench for soc_dmem_arbiter: IDLE-cycle vector table, corner sequences,
// then randomized traffic checked against a transaction-level memory model.
module tb_soc_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        core_en, core_sw, core_sbyte, core_shalf;
  logic [63:0] core_addr, core_wdata;
  logic [63:0] core_rdata;
  logic        core_rvalid, stall, misalign;
  logic        dma_valid, dma_we;
  logic [9:0]  dma_addr;
  logic [63:0] dma_wdata, dma_rdata;
  logic        dma_ready, dma_rvalid;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_rdata;

  logic [63:0] mem     [0:1023];
  logic [63:0] ref_mem [0:1023];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [63:0] pl_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  soc_dmem_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_core_ram_en(core_en), .i_core_sw(core_sw), .i_core_sbyte(core_sbyte),
    .i_core_shalf(core_shalf), .i_core_addr(core_addr), .i_core_wdata(core_wdata),
    .o_core_rdata(core_rdata), .o_core_rvalid(core_rvalid), .o_stall(stall),
    .o_misalign(misalign), .i_dma_valid(dma_valid), .i_dma_we(dma_we),
    .i_dma_waddr(dma_addr), .i_dma_wdata(dma_wdata), .o_dma_ready(dma_ready),
    .o_dma_rdata(dma_rdata), .o_dma_rvalid(dma_rvalid), .o_ram_en(ram_en),
    .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  // Behavioural single-port RAM: read data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] = pl_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    core_en = 0; core_sw = 0; core_sbyte = 0; core_shalf = 0;
    core_addr = '0; core_wdata = '0;
    dma_valid = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic preload(input int a, input logic [63:0] d);
    pl_we = 1'b1; pl_addr = 10'(a); pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic drive_core(input logic sw, input logic sb, input logic sh,
                            input logic [63:0] a, input logic [63:0] d);
    core_en = 1; core_sw = sw; core_sbyte = sb; core_shalf = sh;
    core_addr = a; core_wdata = d;
  endtask

  typedef struct {
    logic c_en, c_sw, c_byte, c_half;
    logic [63:0] c_addr, c_wdata;
    logic d_val, d_we;
    logic [9:0] d_addr;
    logic [63:0] d_wdata;
    logic e_en, e_we;
    logic [9:0] e_addr;
    logic [63:0] e_wdata;
    logic e_stall, e_mis, e_rdy;
  } vec_t;

  vec_t vecs [12];
  logic [63:0] dq [$];

  task automatic new_core_op();
    int k;
    k = $urandom_range(0, 9);
    core_en    = (k != 0);
    core_sw    = (k >= 4);
    core_sbyte = (k == 4 || k == 5 || k == 8);
    core_shalf = (k == 6 || k == 7 || k == 8);
    core_addr  = 64'($urandom_range(0, 7) * 8 + $urandom_range(0, 7));
    core_wdata = {$urandom, $urandom};
  endtask

  task automatic new_dma_op();
    dma_valid = ($urandom_range(0, 2) != 0);
    dma_we    = $urandom_range(0, 1) == 1;
    dma_addr  = 10'($urandom_range(0, 7));
    dma_wdata = {$urandom, $urandom};
  endtask

  initial begin
    logic [63:0] old_w;
    int grants, got, pend, w, off;
    logic dacc, cret;

    rst = 1'b1;
    idle_inputs();
    ram_rdata = '0;
    @(posedge clk); #1;

    // reset state
    @(negedge clk);
    check("reset_ram_en", ram_en, 0);
    check("reset_stall", stall, 0);
    check("reset_dma_ready", dma_ready, 0);

    //          en   sw   byte half addr                 wdata              dv   dwe  daddr  dwdata               e_en e_we e_addr  e_wdata             st   mis  rdy
    vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,64'h10,             64'hDEADBEEF,      1'b0,1'b0,10'd0, 64'h0,               1'b1,1'b1,10'd2,  64'hDEADBEEF,       1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,64'h10,             64'h0,             1'b0,1'b0,10'd0, 64'h0,               1'b1,1'b0,10'd2,  64'h0,              1'b1,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b1,1'b1,1'b0,64'h13,             64'hAA,            1'b0,1'b0,10'd0, 64'h0,               1'b1,1'b0,10'd2,  64'h0,              1'b1,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b1,64'h11,             64'hBEEF,          1'b0,1'b0,10'd0, 64'h0,               1'b0,1'b0,10'd0,  64'h0,              1'b0,1'b1,1'b0};
    vecs[4]  = '{1'b1,1'b1,1'b0,1'b1,64'h12,             64'hBEEF,          1'b0,1'b0,10'd0, 64'h0,               1'b1,1'b0,10'd2,  64'h0,              1'b1,1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b1,1'b1,1'b1,64'h11,             64'h77,            1'b0,1'b0,10'd0, 64'h0,               1'b1,1'b0,10'd2,  64'h0,              1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,64'h10,             64'h1234,          1'b0,1'b0,10'd0, 64'h0,               1'b0,1'b0,10'd0,  64'h0,              1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,              64'h0,             1'b1,1'b1,10'd7, 64'h0123456789ABCDEF,1'b1,1'b1,10'd7,  64'h0123456789ABCDEF,1'b0,1'b0,1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,              64'h0,             1'b1,1'b0,10'd5, 64'h0,               1'b1,1'b0,10'd5,  64'h0,              1'b0,1'b0,1'b1};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,64'h28,             64'h0,             1'b1,1'b1,10'd3, 64'h55,              1'b1,1'b0,10'd5,  64'h0,              1'b1,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b0,64'h1_0000_1FF8,    64'hFEEDF00D,      1'b0,1'b0,10'd0, 64'h0,               1'b1,1'b1,10'd1023,64'hFEEDF00D,      1'b0,1'b0,1'b0};
    vecs[11] = '{1'b1,1'b1,1'b0,1'b1,64'h16,             64'hCAFE,          1'b0,1'b0,10'd0, 64'h0,               1'b1,1'b0,10'd2,  64'h0,              1'b1,1'b0,1'b0};

    for (int i = 0; i < 12; i++) begin
      reset_dut();
      core_en = vecs[i].c_en; core_sw = vecs[i].c_sw;
      core_sbyte = vecs[i].c_byte; core_shalf = vecs[i].c_half;
      core_addr = vecs[i].c_addr; core_wdata = vecs[i].c_wdata;
      dma_valid = vecs[i].d_val; dma_we = vecs[i].d_we;
      dma_addr = vecs[i].d_addr; dma_wdata = vecs[i].d_wdata;
      @(negedge clk);
      check($sformatf("vec%0d_ram_en", i), ram_en, vecs[i].e_en);
      check($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].e_we);
      check($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
      check($sformatf("vec%0d_misalign", i), misalign, vecs[i].e_mis);
      check($sformatf("vec%0d_dma_ready", i), dma_ready, vecs[i].e_rdy);
      if (vecs[i].e_en) check($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
      if (vecs[i].e_we) check($sformatf("vec%0d_ram_wdata", i), ram_wdata, vecs[i].e_wdata);
      @(posedge clk); #1;
    end

    // full-word store then load
    rst = 1'b1; idle_inputs();
    preload(2, 64'h0); preload(5, 64'h5555_AAAA_0000_FFFF); preload(9, 64'h0);
    reset_dut();
    drive_core(1, 0, 0, 64'h10, 64'hDEADBEEF);
    @(negedge clk);
    check("sw_we", ram_we, 1); check("sw_addr", ram_addr, 2); check("sw_stall", stall, 0);
    @(posedge clk); #1;
    drive_core(0, 0, 0, 64'h10, 64'h0);
    @(negedge clk);
    check("ld_stall_issue", stall, 1); check("ld_rvalid_early", core_rvalid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ld_rvalid", core_rvalid, 1); check("ld_rdata", core_rdata, 64'hDEADBEEF);
    check("ld_stall_done", stall, 0);
    @(posedge clk); #1;
    idle_inputs();

    // byte read-modify-write
    rst = 1'b1; preload(2, 64'h1122334455667788); reset_dut();
    drive_core(1, 1, 0, 64'h13, 64'hAA);
    @(negedge clk);
    check("rmw_stall", stall, 1); check("rmw_rd_we", ram_we, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rmw_we", ram_we, 1); check("rmw_wdata", ram_wdata, 64'h11223344AA667788);
    check("rmw_stall_done", stall, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("rmw_mem", mem[2], 64'h11223344AA667788);

    // misaligned half store is dropped
    @(posedge clk); #1;
    drive_core(1, 0, 1, 64'h11, 64'hBEEF);
    @(negedge clk);
    check("mis_pulse", misalign, 1); check("mis_ram_en", ram_en, 0); check("mis_stall", stall, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("mis_pulse_end", misalign, 0);
    check("mis_mem", mem[2], 64'h11223344AA667788);

    // reset during RMW_MERGE aborts the write
    @(posedge clk); #1;
    drive_core(1, 1, 0, 64'h10, 64'h99);
    @(negedge clk);
    check("rstrmw_stall", stall, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstrmw_we", ram_we, 0); check("rstrmw_en", ram_en, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("rstrmw_outs", {ram_en, ram_we, stall, misalign, core_rvalid, dma_ready, dma_rvalid}, 0);
    check("rstrmw_data", ram_wdata | core_rdata | dma_rdata | 64'(ram_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstrmw_mem", mem[2], 64'h11223344AA667788);

    // starvation: DMA waits behind back-to-back loads
    @(posedge clk); #1;
    reset_dut();
    drive_core(0, 0, 0, 64'h10, 64'h0);
    dma_valid = 1; dma_we = 1; dma_addr = 10'd9; dma_wdata = 64'hC0FFEE00_12345678;
    grants = 0; got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      @(negedge clk);
      if (dma_ready) begin
        got = 1;
        check("starve_grants", 64'(grants), 4);
        check("starve_stall", stall, 1);
      end else if (core_rvalid) grants++;
      @(posedge clk); #1;
    end
    check("starve_dma_granted", 64'(got), 1);
    dma_valid = 0;
    @(negedge clk);
    check("starve_replay_en", ram_en, 1); check("starve_replay_we", ram_we, 0);
    check("starve_replay_stall", stall, 1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("starve_mem", mem[9], 64'hC0FFEE00_12345678);

    // DMA read while core idle
    @(posedge clk); #1;
    reset_dut();
    dma_valid = 1; dma_we = 0; dma_addr = 10'd5;
    @(negedge clk);
    check("dmard_ready", dma_ready, 1); check("dmard_addr", ram_addr, 5);
    @(posedge clk); #1;
    @(negedge clk);
    check("dmard_rvalid", dma_rvalid, 1); check("dmard_rdata", dma_rdata, 64'h5555_AAAA_0000_FFFF);
    check("dmard_ready_busy", dma_ready, 0);
    @(posedge clk); #1;
    idle_inputs();

    // randomized traffic against the memory model
    rst = 1'b1;
    for (int a = 0; a < 8; a++) preload(a, {$urandom, $urandom});
    reset_dut();
    new_core_op(); new_dma_op();
    pend = 0;
    for (int cyc = 0; cyc < 3020; cyc++) begin
      @(negedge clk);
      if (dma_rvalid) begin
        check("rnd_dma_rvalid_expected", 64'(dq.size() != 0), 1);
        if (dq.size() != 0) check("rnd_dma_rdata", dma_rdata, dq.pop_front());
      end
      dacc = dma_valid && dma_ready;
      cret = core_en && !stall;
      if (dacc) begin
        if (dma_we) ref_mem[dma_addr] = dma_wdata;
        else dq.push_back(ref_mem[dma_addr]);
      end
      if (cret) begin
        w = int'(core_addr[12:3]); off = int'(core_addr[2:0]);
        if (!core_sw) begin
          check("rnd_ld_rvalid", core_rvalid, 1);
          check("rnd_ld_rdata", core_rdata, ref_mem[w]);
        end else if (core_sbyte) ref_mem[w][off*8 +: 8] = core_wdata[7:0];
        else if (core_shalf) begin
          if (off % 2 == 1) check("rnd_misalign", misalign, 1);
          else ref_mem[w][off*8 +: 16] = core_wdata[15:0];
        end else ref_mem[w] = core_wdata;
        pend = 0;
      end else if (core_en) begin
        pend++;
        if (pend > 8) begin
          check("rnd_core_progress", 64'(pend), 8);
          pend = 0;
        end
      end
      @(posedge clk); #1;
      if (cret || !core_en) begin
        if (cyc < 3000) new_core_op();
        else begin core_en = 0; core_sw = 0; core_sbyte = 0; core_shalf = 0; end
      end
      if (dacc || !dma_valid) begin
        if (cyc < 3000) new_dma_op();
        else dma_valid = 0;
      end
    end
    check("rnd_dma_drained", 64'(dq.size()), 0);
    for (int a = 0; a < 8; a++) check($sformatf("rnd_mem%0d", a), mem[a], ref_mem[a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
